// File: rtl/mem_bus_if.sv
// Control-bus bundle between the CPU core (master) and the memory responder (slave),
// including the preload port used to load program ROM before the core starts.
interface mem_bus_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              busy;
  logic              err;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  modport master (
    output rd, wr, addr, wdata, init_we, init_addr, init_data,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  rd, wr, addr, wdata, init_we, init_addr, init_data,
    output rdata, ack, busy, err
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the CPU control bus: edge-detected rd/wr strobes, a
// programmable wait period, a one-cycle ack, and a write-protected ROM region.
module mem_bus_responder #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int WAIT_CYC = 1,
  parameter int ROM_TOP  = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  mem_bus_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [ADDR_W:0] ROM_LIM = (ADDR_W + 1)'(ROM_TOP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACC,
    S_HOLD
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  // Strobe history; hist_valid_q blocks a "start" until one real sample exists.
  logic strobe_prev_q;
  logic hist_valid_q;

  logic              op_wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] rdata_q;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic              capture;
  logic              rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  logic strobe;
  logic start;

  assign strobe = bus.rd | bus.wr;
  assign start  = hist_valid_q & strobe & ~strobe_prev_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    err_d     = err_q;
    ack_d     = 1'b0;
    capture   = 1'b0;
    rd_acc    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = bus.init_addr;
    mem_wdata = bus.init_data;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (bus.rd && bus.wr) begin
            err_d   = 1'b1;
            state_d = S_HOLD;
          end else begin
            capture = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = (WAIT_CYC > 0) ? S_WAIT : S_ACC;
          end
        end else if (bus.init_we) begin
          mem_we = 1'b1;
        end
      end

      S_WAIT: begin
        if (!strobe) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = S_ACC;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      S_ACC: begin
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_HOLD;
        if (op_wr_q) begin
          if ({1'b0, addr_q} >= ROM_LIM) begin
            mem_we    = 1'b1;
            mem_waddr = addr_q;
            mem_wdata = wdata_q;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          rd_acc = 1'b1;
        end
      end

      S_HOLD: begin
        if (!strobe) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      strobe_prev_q <= 1'b0;
      hist_valid_q  <= 1'b0;
      op_wr_q       <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      strobe_prev_q <= strobe;
      hist_valid_q  <= 1'b1;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
      if (capture) begin
        op_wr_q <= bus.wr;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      if (rd_acc) rdata_q <= mem[addr_q];
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: three instances (WAIT_CYC = 1, 3, 0) share one stimulus
// stream and are compared every cycle against a transaction-timeline model.
module tb_mem_bus_responder;

  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 5;
  localparam int ROM_TOP = 16;
  localparam int DEPTH   = 32;
  localparam int NDUT    = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd = 1'b0;
  logic       wr = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       init_we = 1'b0;
  logic [4:0] init_addr = '0;
  logic [7:0] init_data = '0;

  logic [NDUT-1:0] ack_o;
  logic [NDUT-1:0] busy_o;
  logic [NDUT-1:0] err_o;
  logic [7:0]      rdata_o [NDUT];

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  function automatic int wait_of(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 0;
  endfunction

  for (genvar gi = 0; gi < NDUT; gi++) begin : g
    localparam int W = (gi == 0) ? 1 : (gi == 1) ? 3 : 0;
    mem_bus_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    mem_bus_responder #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_CYC(W), .ROM_TOP(ROM_TOP)
    ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );
    assign bus.rd        = rd;
    assign bus.wr        = wr;
    assign bus.addr      = addr;
    assign bus.wdata     = wdata;
    assign bus.init_we   = init_we;
    assign bus.init_addr = init_addr;
    assign bus.init_data = init_data;
    assign ack_o[gi]     = bus.ack;
    assign busy_o[gi]    = bus.busy;
    assign err_o[gi]     = bus.err;
    assign rdata_o[gi]   = bus.rdata;
  end

  // Reference model: each access is a timeline (capture edge, completion edge), not a state machine.
  logic       exp_ack   [NDUT];
  logic       exp_busy  [NDUT];
  logic       exp_err   [NDUT];
  logic [7:0] exp_rdata [NDUT];
  bit         pend      [NDUT];
  bit         blocked   [NDUT];
  int         due       [NDUT];
  bit         m_wr      [NDUT];
  logic [4:0] m_addr    [NDUT];
  logic [7:0] m_data    [NDUT];
  logic [7:0] mmem      [NDUT][DEPTH];
  bit         seen = 1'b0;
  bit         prev = 1'b0;
  int         edge_n = 0;

  task automatic model_reset();
    for (int i = 0; i < NDUT; i++) begin
      exp_ack[i] = 1'b0; exp_busy[i] = 1'b0; exp_err[i] = 1'b0; exp_rdata[i] = '0;
      pend[i] = 1'b0; blocked[i] = 1'b0;
    end
    seen = 1'b0;
    prev = 1'b0;
  endtask

  task automatic model_edge();
    bit cur;
    bit start;
    cur   = rd | wr;
    start = seen && cur && !prev;
    edge_n++;
    for (int i = 0; i < NDUT; i++) begin
      exp_ack[i] = 1'b0;
      if (pend[i]) begin
        if (edge_n == due[i]) begin
          if (m_wr[i]) begin
            if (int'(m_addr[i]) >= ROM_TOP) mmem[i][m_addr[i]] = m_data[i];
            else exp_err[i] = 1'b1;
          end else begin
            exp_rdata[i] = mmem[i][m_addr[i]];
          end
          exp_ack[i] = 1'b1; exp_busy[i] = 1'b0; pend[i] = 1'b0; blocked[i] = 1'b1;
        end else if (!cur) begin
          pend[i] = 1'b0; exp_busy[i] = 1'b0;
        end
      end else if (blocked[i]) begin
        if (!cur) blocked[i] = 1'b0;
      end else if (start) begin
        if (rd && wr) begin
          exp_err[i] = 1'b1; blocked[i] = 1'b1;
        end else begin
          pend[i] = 1'b1; due[i] = edge_n + wait_of(i) + 1;
          m_wr[i] = wr; m_addr[i] = addr; m_data[i] = wdata; exp_busy[i] = 1'b1;
        end
      end else if (init_we) begin
        mmem[i][init_addr] = init_data;
      end
    end
    prev = cur;
    seen = 1'b1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs only change #1 after an edge, so the model sees exactly what the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic access(input bit r, input bit w, input logic [4:0] a, input logic [7:0] d,
                        input int hold);
    rd = r; wr = w; addr = a; wdata = d;
    repeat (hold) tick();
    rd = 1'b0; wr = 1'b0;
    repeat (2) tick();
  endtask

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("d%0d.ack", i),   {7'd0, ack_o[i]},  {7'd0, exp_ack[i]});
        check($sformatf("d%0d.busy", i),  {7'd0, busy_o[i]}, {7'd0, exp_busy[i]});
        check($sformatf("d%0d.err", i),   {7'd0, err_o[i]},  {7'd0, exp_err[i]});
        check($sformatf("d%0d.rdata", i), rdata_o[i],        exp_rdata[i]);
      end
    end
  end

  initial begin
    int acks [NDUT];
    model_reset();
    tick(); tick();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("rst.ack%0d", i),   {7'd0, ack_o[i]},  8'd0);
      check($sformatf("rst.busy%0d", i),  {7'd0, busy_o[i]}, 8'd0);
      check($sformatf("rst.err%0d", i),   {7'd0, err_o[i]},  8'd0);
      check($sformatf("rst.rdata%0d", i), rdata_o[i],        8'd0);
    end
    rst_n = 1'b1;
    checking = 1'b1;

    for (int a = 0; a < DEPTH; a++) begin
      init_we = 1'b1; init_addr = 5'(a);
      init_data = (a == 3) ? 8'hA5 : (a == 5) ? 8'h5A : (a == 25) ? 8'hC3 : 8'($urandom);
      tick();
    end
    init_we = 1'b0;
    tick();

    // Read of preloaded word: ack two edges after capture for WAIT_CYC=1.
    rd = 1'b1; addr = 5'd3;
    tick();
    check("t1.busy_k", {7'd0, busy_o[0]}, 8'd1);
    check("t1.ack_k",  {7'd0, ack_o[0]},  8'd0);
    tick();
    check("t1.busy_k1", {7'd0, busy_o[0]}, 8'd1);
    rd = 1'b0;
    tick();
    check("t1.ack_k2",   {7'd0, ack_o[0]},  8'd1);
    check("t1.rdata",    rdata_o[0],        8'hA5);
    check("t1.busy_k2",  {7'd0, busy_o[0]}, 8'd0);
    check("t1.model",    exp_rdata[0],      8'hA5);
    check("t4.abort_busy",  {7'd0, busy_o[1]}, 8'd0);
    check("t4.abort_ack",   {7'd0, ack_o[1]},  8'd0);
    check("t4.abort_rdata", rdata_o[1],        8'h00);
    check("w0.rdata",       rdata_o[2],        8'hA5);
    tick();
    check("t1.ack_gone", {7'd0, ack_o[0]}, 8'd0);

    // RAM write then readback.
    access(1'b0, 1'b1, 5'd20, 8'h3C, 6);
    access(1'b1, 1'b0, 5'd20, 8'h00, 6);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("t2.rdata%0d", i), rdata_o[i], 8'h3C);
      check($sformatf("t2.err%0d", i), {7'd0, err_o[i]}, 8'd0);
    end

    // ROM write is refused and flagged.
    access(1'b0, 1'b1, 5'd5, 8'hFF, 6);
    for (int i = 0; i < NDUT; i++) check($sformatf("t3.err%0d", i), {7'd0, err_o[i]}, 8'd1);
    access(1'b1, 1'b0, 5'd5, 8'h00, 6);
    for (int i = 0; i < NDUT; i++) check($sformatf("t3.rom%0d", i), rdata_o[i], 8'h5A);

    // A long strobe yields exactly one ack.
    for (int i = 0; i < NDUT; i++) acks[i] = 0;
    rd = 1'b1; addr = 5'd20;
    repeat (8) begin
      tick();
      for (int i = 0; i < NDUT; i++) acks[i] += int'(ack_o[i]);
    end
    rd = 1'b0;
    repeat (2) tick();
    for (int i = 0; i < NDUT; i++) check($sformatf("t6.acks%0d", i), 8'(acks[i]), 8'd1);

    // Reset while a write waits: outputs clear and the word keeps its old value.
    wr = 1'b1; addr = 5'd25; wdata = 8'h77;
    tick(); tick();
    rst_n = 1'b0; model_reset(); wr = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("t6.rst_busy%0d", i), {7'd0, busy_o[i]}, 8'd0);
      check($sformatf("t6.rst_err%0d", i),  {7'd0, err_o[i]},  8'd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    access(1'b1, 1'b0, 5'd25, 8'h00, 6);
    for (int i = 0; i < 2; i++) check($sformatf("t6.kept%0d", i), rdata_o[i], 8'hC3);

    // Strobe already high when reset releases: no access starts.
    rd = 1'b1; addr = 5'd3;
    rst_n = 1'b0; model_reset();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    for (int i = 0; i < NDUT; i++) check($sformatf("nostart%0d", i), {7'd0, busy_o[i]}, 8'd0);
    rd = 1'b0;
    repeat (2) tick();

    // rd and wr together: error, no access; a later read works normally.
    rd = 1'b1; wr = 1'b1; addr = 5'd22; wdata = 8'h11;
    tick();
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("t5.err%0d", i),  {7'd0, err_o[i]},  8'd1);
      check($sformatf("t5.busy%0d", i), {7'd0, busy_o[i]}, 8'd0);
    end
    tick(); tick();
    rd = 1'b0; wr = 1'b0;
    repeat (2) tick();
    access(1'b1, 1'b0, 5'd3, 8'h00, 6);
    for (int i = 0; i < NDUT; i++) check($sformatf("t5.read%0d", i), rdata_o[i], 8'hA5);

    // Randomised traffic with occasional resets.
    repeat (4000) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; init_we = 1'b0; model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        if ($urandom_range(0, 9) < 3) rd = ~rd;
        if ($urandom_range(0, 9) < 2) wr = ~wr;
        addr      = 5'($urandom);
        wdata     = 8'($urandom);
        init_we   = ($urandom_range(0, 9) == 0);
        init_addr = 5'($urandom);
        init_data = 8'($urandom);
        tick();
      end
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
